// File: rtl/serializador.sv
// Parallel-to-serial stage for 8b/10b symbols: MSB-first shifter fed from a one-word
// holding register, inserting alternating-disparity K28.5 commas when nothing is pending.
module serializador #(
  parameter int unsigned       ANCHO    = 10,
  parameter logic [ANCHO-1:0]  COMA_RDN = 10'b0011111010,
  parameter logic [ANCHO-1:0]  COMA_RDP = 10'b1100000101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [ANCHO-1:0] entradas,
  input  logic             valido,
  output logic             listo,
  output logic             salida,
  output logic             inicio,
  output logic             esComa
);

  localparam int unsigned CW = $clog2(ANCHO);
  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

  typedef enum logic {
    INACTIVO = 1'b0,
    TX       = 1'b1
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] sr_q, sr_d;
  logic [ANCHO-1:0] hold_q, hold_d;
  logic             lleno_q, lleno_d;
  logic [CW-1:0]    contador_q, contador_d;
  logic             rd_q, rd_d;
  logic             coma_q, coma_d;

  logic carga_c;
  logic acepta_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q   <= INACTIVO;
      sr_q       <= '0;
      hold_q     <= '0;
      lleno_q    <= 1'b0;
      contador_q <= '0;
      rd_q       <= 1'b0;
      coma_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      lleno_q    <= lleno_d;
      contador_q <= contador_d;
      rd_q       <= rd_d;
      coma_q     <= coma_d;
    end
  end

  // A word boundary is either leaving idle or the edge after the last bit
  assign carga_c  = enb && ((estado_q == INACTIVO) || (contador_q == ULTIMO));
  assign acepta_c = valido && listo;

  // Next-state logic
  always_comb begin
    estado_d   = estado_q;
    sr_d       = sr_q;
    hold_d     = hold_q;
    lleno_d    = lleno_q;
    contador_d = contador_q;
    rd_d       = rd_q;
    coma_d     = coma_q;

    if (!enb) begin
      // Dropping enable discards the word in flight but keeps the pending symbol
      estado_d   = INACTIVO;
      contador_d = '0;
      sr_d       = '0;
    end else if (carga_c) begin
      if (lleno_q) begin
        sr_d    = hold_q;
        lleno_d = 1'b0;
        coma_d  = 1'b0;
      end else begin
        sr_d   = rd_q ? COMA_RDP : COMA_RDN;
        rd_d   = ~rd_q;
        coma_d = 1'b1;
      end
      contador_d = '0;
      estado_d   = TX;
    end else begin
      sr_d       = {sr_q[ANCHO-2:0], 1'b0};
      contador_d = contador_q + CW'(1);
    end

    // listo implies the holding register was empty, so this never collides with a drain
    if (acepta_c) begin
      hold_d  = entradas;
      lleno_d = 1'b1;
    end
  end

  assign listo  = enb && !lleno_q;
  assign salida = sr_q[ANCHO-1];
  assign inicio = (estado_q == TX) && (contador_q == '0);
  assign esComa = (estado_q == TX) && coma_q;

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: reset vector table plus scoreboarded serial stream per cycle.
module tb_serializador;

  localparam logic [9:0] RDN = 10'b0011111010;
  localparam logic [9:0] RDP = 10'b1100000101;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       valido;
  logic [9:0] entradas;
  logic       listo;
  logic       salida;
  logic       inicio;
  logic       esComa;

  serializador #(
    .ANCHO   (10),
    .COMA_RDN(RDN),
    .COMA_RDP(RDP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enb     (enb),
    .entradas(entradas),
    .valido  (valido),
    .listo   (listo),
    .salida  (salida),
    .inicio  (inicio),
    .esComa  (esComa)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic salida;
    logic inicio;
    logic coma;
  } obs_t;

  typedef struct {
    logic       enb;
    logic       valido;
    logic [9:0] entradas;
    logic       exp_salida;
    logic       exp_inicio;
    logic       exp_coma;
    logic       exp_listo;
  } vec_t;

  obs_t       exp_q[$];
  logic [9:0] tx_q[$];
  int         rachas_q[$];
  int         checks = 0;
  int         passed = 0;
  logic       trk = 1'b0;
  int         racha = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected serial bits of a word, MSB first, inicio on the first bit
  task automatic push_bits(input logic [9:0] w, input logic coma, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e.salida = w[9-i];
      e.inicio = (i == 0);
      e.coma   = coma;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    obs_t e;
    e = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One clock per iteration: compare against scoreboard, then advance the source
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      logic acc;
      obs_t e;
      acc = valido & listo;
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty: got output with no expectation at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check1("salida", salida, e.salida);
        check1("inicio", inicio, e.inicio);
        check1("esComa", esComa, e.coma);
      end
      if (trk) begin
        if (!listo) racha++;
        else if (racha > 0) begin
          rachas_q.push_back(racha);
          racha = 0;
        end
      end
      if (acc) begin
        if (tx_q.size() > 0) entradas = tx_q.pop_front();
        else valido = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t tabla[5];
    tabla[0] = '{1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1};
    tabla[1] = '{1'b0, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[2] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    tabla[3] = '{1'b0, 1'b0, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[4] = '{1'b1, 1'b1, 10'h1A5, 1'b0, 1'b0, 1'b0, 1'b1};

    rst      = 1'b0;
    enb      = 1'b0;
    valido   = 1'b0;
    entradas = '0;
    @(negedge clk);

    // Held in reset: outputs stay at reset values across edges, listo follows enb
    for (int i = 0; i < 5; i++) begin
      enb      = tabla[i].enb;
      valido   = tabla[i].valido;
      entradas = tabla[i].entradas;
      @(posedge clk);
      @(negedge clk);
      check1("rst_salida", salida, tabla[i].exp_salida);
      check1("rst_inicio", inicio, tabla[i].exp_inicio);
      check1("rst_esComa", esComa, tabla[i].exp_coma);
      check1("rst_listo",  listo,  tabla[i].exp_listo);
    end

    // Idle commas with alternating disparity
    enb    = 1'b1;
    valido = 1'b0;
    rst    = 1'b1;
    push_bits(RDN, 1'b1, 10);
    push_bits(RDP, 1'b1, 10);
    push_bits(RDN, 1'b1, 10);
    push_bits(RDP, 1'b1, 10);
    push_bits(RDN, 1'b1, 10);
    run(50);

    // Single word accepted mid-comma goes out at the next boundary
    push_bits(RDP, 1'b1, 10);
    run(3);
    valido   = 1'b1;
    entradas = 10'b1010011100;
    push_bits(10'b1010011100, 1'b0, 10);
    push_bits(RDN, 1'b1, 10);
    run(1);
    check1("listo_lleno", listo, 1'b0);
    run(26);

    // Back-to-back words with valido held high
    valido   = 1'b1;
    entradas = 10'h2AA;
    tx_q.push_back(10'h155);
    push_bits(RDP, 1'b1, 10);
    push_bits(10'h2AA, 1'b0, 10);
    push_bits(10'h155, 1'b0, 10);
    push_bits(RDN, 1'b1, 10);
    trk   = 1'b1;
    racha = 0;
    run(40);
    trk = 1'b0;
    check_int("listo_runs", rachas_q.size(), 2);
    if (rachas_q.size() == 2) begin
      check_int("listo_low_run0", rachas_q[0], 10);
      check_int("listo_low_run1", rachas_q[1], 9);
    end

    // enb dropped mid-word with a pending symbol
    valido   = 1'b1;
    entradas = 10'h3C0;
    push_bits(RDP, 1'b1, 5);
    run(5);
    enb = 1'b0;
    push_idle(3);
    run(3);
    check1("listo_enb0", listo, 1'b0);
    enb = 1'b1;
    push_bits(10'h3C0, 1'b0, 10);
    push_bits(RDN, 1'b1, 10);
    push_bits(RDP, 1'b1, 10);
    run(30);

    // Mid-word asynchronous reset with hold full and rd at RD+
    push_bits(RDN, 1'b1, 10);
    run(3);
    valido   = 1'b1;
    entradas = 10'h3FF;
    run(1);
    check1("pre_rst_salida", salida, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check1("async_salida", salida, 1'b0);
    check1("async_inicio", inicio, 1'b0);
    check1("async_esComa", esComa, 1'b0);
    check1("async_listo",  listo,  1'b1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    push_bits(RDN, 1'b1, 10);
    push_bits(RDP, 1'b1, 10);
    run(20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
